// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register index width, the XZR index and the
// hazard unit's state type.
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_XZR = 5'd31;

    typedef enum logic {
        HZ_RUN,
        HZ_HOLD
    } hz_state_t;

endpackage : cpu_pkg

// File: rtl/reg_idx_eq.sv
// Register index equality comparator used to match ID source operands
// against the EX destination.
module reg_idx_eq
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx_a,
    input  logic [REG_IDX_W-1:0] idx_b,
    output logic                 eq
);

    assign eq = (idx_a == idx_b);

endmodule : reg_idx_eq

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard unit: one bubble per load-use consumer, IF/ID squash on a
// taken branch, and stall/flush event counters.
module hazard_detect_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Aa_id,
    input  logic [4:0]       Ab_id,
    input  logic             uses_Aa_id,
    input  logic             uses_Ab_id,
    input  logic             is_branch_id,
    input  logic             br_taken_id,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic             regwrite_ex,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic aa_eq, ab_eq;
    logic lu_hit;
    logic br_take;

    reg_idx_eq u_aa_eq (
        .idx_a (Aa_id),
        .idx_b (rd_ex),
        .eq    (aa_eq)
    );

    reg_idx_eq u_ab_eq (
        .idx_a (Ab_id),
        .idx_b (rd_ex),
        .eq    (ab_eq)
    );

    // XZR is never a real producer, so a load "into" it cannot create a hazard.
    assign lu_hit = memread_ex & regwrite_ex & (rd_ex != REG_XZR) &
                    ((uses_Aa_id & aa_eq) | (uses_Ab_id & ab_eq));
    assign br_take = is_branch_id & br_taken_id;

    always_comb begin
        state_d       = state_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        stall_active  = 1'b0;

        if (reset) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            state_d       = HZ_RUN;
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    // A stall outranks a taken branch: the branch is re-evaluated
                    // in HOLD once the load data can be forwarded from MEM.
                    if (lu_hit) begin
                        pc_write      = 1'b0;
                        ifid_write    = 1'b0;
                        idex_bubble   = 1'b1;
                        stall_active  = 1'b1;
                        state_d       = HZ_HOLD;
                        stall_count_d = stall_count_q + CNT_ONE;
                    end else if (br_take) begin
                        ifid_flush    = 1'b1;
                        flush_count_d = flush_count_q + CNT_ONE;
                    end
                end
                HZ_HOLD: begin
                    // lu_hit is deliberately ignored: the same consumer never stalls twice.
                    state_d = HZ_RUN;
                    if (br_take) begin
                        ifid_flush    = 1'b1;
                        flush_count_d = flush_count_q + CNT_ONE;
                    end
                end
                default: state_d = HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HZ_RUN;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule : hazard_detect_unit

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed pipeline scenarios plus random
// stimulus against a cycle-level behavioural model; a 2-bit-counter copy covers wrap.
module tb_hazard_detect_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  Aa_id, Ab_id, rd_ex;
    logic        uses_Aa_id, uses_Ab_id, is_branch_id, br_taken_id, memread_ex, regwrite_ex;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, stall_active;
    logic [31:0] stall_count, flush_count;
    logic        w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble, w_stall_active;
    logic [1:0]  w_stall_count, w_flush_count;

    int total = 0;
    int bad   = 0;

    // Model state: whether the previous cycle inserted a bubble, and event totals.
    bit              m_prev_stall;
    longint unsigned m_stalls, m_flushes;
    bit              exp_stall, exp_flush;
    logic [4:0]      exp_outs;

    hazard_detect_unit dut (
        .clk(clk), .reset(reset), .Aa_id(Aa_id), .Ab_id(Ab_id),
        .uses_Aa_id(uses_Aa_id), .uses_Ab_id(uses_Ab_id),
        .is_branch_id(is_branch_id), .br_taken_id(br_taken_id),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .stall_active(stall_active),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_detect_unit #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .Aa_id(Aa_id), .Ab_id(Ab_id),
        .uses_Aa_id(uses_Aa_id), .uses_Ab_id(uses_Ab_id),
        .is_branch_id(is_branch_id), .br_taken_id(br_taken_id),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
        .pc_write(w_pc_write), .ifid_write(w_ifid_write), .ifid_flush(w_ifid_flush),
        .idex_bubble(w_idex_bubble), .stall_active(w_stall_active),
        .stall_count(w_stall_count), .flush_count(w_flush_count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic set_in(input logic [4:0] aa, input logic ua, input logic [4:0] ab,
                          input logic ub, input logic [4:0] rd, input logic mr,
                          input logic rw, input logic br, input logic tk);
        Aa_id = aa; uses_Aa_id = ua; Ab_id = ab; uses_Ab_id = ub;
        rd_ex = rd; memread_ex = mr; regwrite_ex = rw;
        is_branch_id = br; br_taken_id = tk;
    endtask

    function automatic bit load_use();
        return memread_ex && regwrite_ex && (rd_ex != 5'd31) &&
               ((uses_Aa_id && Aa_id == rd_ex) || (uses_Ab_id && Ab_id == rd_ex));
    endfunction

    // Expected outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}.
    task automatic model_eval();
        exp_stall = !reset && load_use() && !m_prev_stall;
        exp_flush = !reset && !exp_stall && is_branch_id && br_taken_id;
        if (reset)          exp_outs = 5'b00110;
        else if (exp_stall) exp_outs = 5'b00011;
        else                exp_outs = {2'b11, exp_flush, 2'b00};
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_prev_stall = 1'b0;
            m_stalls     = 0;
            m_flushes    = 0;
        end else begin
            m_prev_stall = exp_stall;
            m_stalls     = m_stalls + (exp_stall ? 1 : 0);
            m_flushes    = m_flushes + (exp_flush ? 1 : 0);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        model_eval();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        set_in(5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_active} !== 5'b00110) begin
            bad++;
            $display("FAIL reset_outs got=%b want=00110",
                     {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active});
        end
        total++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        model_eval();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load_use_aa();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0, 1:    set_in(5'd2, 1'b1, 5'd7, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
                default: set_in(5'd9, 1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            model_eval();
            total++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_active} !== exp_outs) begin
                bad++;
                $display("FAIL load_use_aa cyc%0d outs got=%b want=%b", i,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}, exp_outs);
            end
            tick();
        end
        total++;
        if (stall_count !== 32'd1 || flush_count !== 32'd0) begin
            bad++;
            $display("FAIL load_use_aa counts got=%0d/%0d want=1/0", stall_count, flush_count);
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_in(5'd31, 1'b1, 5'd1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
                1:       set_in(5'd4,  1'b1, 5'd5, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0);
                default: set_in(5'd3,  1'b1, 5'd8, 1'b1, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            model_eval();
            total++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_active} !== 5'b11000) begin
                bad++;
                $display("FAIL no_stall cyc%0d outs got=%b want=11000", i,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active});
            end
            tick();
        end
        total++;
        if (stall_count !== 32'd0) begin
            bad++;
            $display("FAIL no_stall stall_count got=%0d want=0", stall_count);
        end
    endtask

    task automatic test_stall_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_in(5'd0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
                1:       set_in(5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
                default: set_in(5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            model_eval();
            total++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_active} !== exp_outs) begin
                bad++;
                $display("FAIL stall_branch cyc%0d outs got=%b want=%b", i,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}, exp_outs);
            end
            tick();
        end
        total++;
        if (stall_count !== 32'd1 || flush_count !== 32'd1) begin
            bad++;
            $display("FAIL stall_branch counts got=%0d/%0d want=1/1", stall_count, flush_count);
        end
    endtask

    task automatic test_back_to_back();
        int run_len = 0;
        int max_run = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       set_in(5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
                1:       set_in(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                2:       set_in(5'd6, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
                3:       set_in(5'd6, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
                default: set_in(5'd7, 1'b1, 5'd8, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            model_eval();
            run_len = stall_active ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            total++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_active} !== exp_outs) begin
                bad++;
                $display("FAIL back_to_back cyc%0d outs got=%b want=%b", i,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}, exp_outs);
            end
            tick();
        end
        total++;
        if (stall_count !== 32'd2 || max_run !== 1) begin
            bad++;
            $display("FAIL back_to_back stalls got=%0d run=%0d want=2 run=1", stall_count, max_run);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            reset = (i == 1);
            set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            model_eval();
            total++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_active} !== exp_outs) begin
                bad++;
                $display("FAIL reset_in_hold cyc%0d outs got=%b want=%b", i,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}, exp_outs);
            end
            if (i == 2) begin
                total++;
                if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
                    bad++;
                    $display("FAIL reset_in_hold counts got=%0d/%0d want=0/0",
                             stall_count, flush_count);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) set_in(5'd9, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
            else            set_in(5'd9, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            model_eval();
            tick();
        end
        total++;
        if (w_stall_count !== 2'd0 || w_flush_count !== 2'd0 || stall_count !== 32'd4 ||
            flush_count !== 32'd4) begin
            bad++;
            $display("FAIL wrap got=%0d/%0d narrow=%0d/%0d want=4/4 narrow=0/0",
                     stall_count, flush_count, w_stall_count, w_flush_count);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            r = $urandom_range(0, 9); Aa_id = (r > 7) ? 5'd31 : 5'(r);
            r = $urandom_range(0, 9); Ab_id = (r > 7) ? 5'd31 : 5'(r);
            r = $urandom_range(0, 9); rd_ex = (r > 7) ? 5'd31 : 5'(r);
            uses_Aa_id   = 1'($urandom_range(0, 1));
            uses_Ab_id   = 1'($urandom_range(0, 1));
            memread_ex   = ($urandom_range(0, 2) != 0);
            regwrite_ex  = ($urandom_range(0, 3) != 0);
            is_branch_id = ($urandom_range(0, 2) == 0);
            br_taken_id  = 1'($urandom_range(0, 1));
            @(negedge clk);
            model_eval();
            total++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_active} !== exp_outs) begin
                bad++;
                $display("FAIL random cyc%0d outs got=%b want=%b", i,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}, exp_outs);
            end
            total++;
            if (stall_count !== m_stalls[31:0] || flush_count !== m_flushes[31:0] ||
                w_stall_count !== m_stalls[1:0] || w_flush_count !== m_flushes[1:0]) begin
                bad++;
                $display("FAIL random cyc%0d counts got=%0d/%0d narrow=%0d/%0d want=%0d/%0d", i,
                         stall_count, flush_count, w_stall_count, w_flush_count,
                         m_stalls, m_flushes);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_prev_stall = 1'b0;
        m_stalls = 0;
        m_flushes = 0;
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use_aa();
        test_no_stall();
        test_stall_branch();
        test_back_to_back();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_detect_unit

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Sits in the decode (ID) stage, directly upstream of the EX-stage forwarding unit.
- Detects load-use hazards that forwarding cannot cover and inserts exactly one bubble into ID/EX while freezing PC and IF/ID.
- Squashes the IF/ID instruction when a branch resolves taken in ID.
- Keeps stall and flush event counters for performance debug.

Parameters:
- CNT_W, 32: width of the stall_count and flush_count counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- Aa_id  input  5  first source register index of the ID instruction
- Ab_id  input  5  second source register index of the ID instruction (Rd for STUR/CBZ)
- uses_Aa_id  input  1  ID instruction reads Aa_id
- uses_Ab_id  input  1  ID instruction reads Ab_id
- is_branch_id  input  1  ID instruction is B, B.cond or CBZ
- br_taken_id  input  1  branch condition true, from ID-stage evaluation with forwarded operands and flags
- rd_ex  input  5  destination index of the EX instruction
- memread_ex  input  1  EX instruction is a load (LDUR)
- regwrite_ex  input  1  EX instruction writes the register file
- pc_write  output  1  PC update enable
- ifid_write  output  1  IF/ID register load enable
- ifid_flush  output  1  clear IF/ID to a NOP on the next edge
- idex_bubble  output  1  zero all ID/EX control bits (regwrite, memwrite, memread, FlagUp, branch) on the next edge
- stall_active  output  1  current cycle is a load-use stall cycle
- stall_count  output  CNT_W  number of bubbles inserted since reset
- flush_count  output  CNT_W  number of taken-branch flushes since reset

Behaviour:
- State machine has two states.
  - RUN: normal operation.
  - HOLD: the cycle after a bubble was inserted.
- Load-use hazard, combinational: lu_hit = memread_ex & regwrite_ex & (rd_ex != 31) & ((uses_Aa_id & Aa_id == rd_ex) | (uses_Ab_id & Ab_id == rd_ex)).
  - Index 31 (XZR) never causes a stall.
- RUN with lu_hit=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, stall_active=1.
  - Next state is HOLD; stall_count increments.
- RUN with lu_hit=0 and is_branch_id & br_taken_id:
  - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0.
  - flush_count increments.
- RUN with neither: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, stall_active=0.
- Simultaneous load hazard and taken branch: the stall wins.
  - The branch stays in ID and is re-evaluated in HOLD, when the load is in MEM and its data arrives through d_mem forwarding.
  - No flush and no flush_count increment in the stall cycle.
- HOLD:
  - lu_hit is ignored: the bubble now occupies EX with regwrite_ex=0, and a second stall for the same consumer is forbidden.
  - Outputs follow the RUN non-hazard rules, including the taken-branch flush.
  - Next state is RUN unconditionally.
- Back-to-back loads: a new hazard from a different load reaching EX is detected in the following RUN cycle. At most one bubble is inserted per consumer instruction.
- Latency:
  - Hazard outputs are combinational, same cycle as detection.
  - Counters and state update on the next rising edge.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset (synchronous, evaluated at the edge):
  - State becomes RUN; stall_count=0; flush_count=0.
  - While reset is high, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, stall_active=0.
- Reset asserted mid-stall (in HOLD): the next state is RUN and no counter increments on that edge.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic {HZ_RUN, HZ_HOLD} hz_state_t
  - constant REG_XZR = 5'd31
  - constant REG_IDX_W = 5
- One sub-module, reg_idx_eq: 5-bit index equality comparator, instantiated twice (Aa_id vs rd_ex, Ab_id vs rd_ex).
- Counters and the state machine stay inline.

Test Plan:
- Load-use on Aa: LDUR X2 in EX (memread_ex=1, regwrite_ex=1, rd_ex=2), ID reads Aa_id=2, uses_Aa_id=1.
  - Required: pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle, then state HOLD with all enables 1.
  - stall_count=1.
- XZR and unused operand:
  - rd_ex=31 with matching Aa_id=31 → no stall.
  - rd_ex=5, Ab_id=5 with uses_Ab_id=0 → no stall.
  - stall_count stays 0.
- ALU producer:
  - memread_ex=0, regwrite_ex=1, rd_ex=3, Aa_id=3 → no stall; forwarding covers it.
- Stall plus taken CBZ:
  - Cycle 0: load in EX with rd_ex=4; CBZ in ID with Ab_id=4, br_taken_id=1 → stall only, ifid_flush=0.
  - Cycle 1 (HOLD), br_taken_id=1 → ifid_flush=1.
  - flush_count=1, stall_count=1.
- Back-to-back loads:
  - LDUR X1 then LDUR X6 using X1 then ADD using X6 → two separate single-cycle bubbles.
  - stall_count=2, never two consecutive stall cycles.
- Reset:
  - reset=1 during HOLD → outputs forced to reset values; after release, state RUN and both counters 0.
  - Preloading stall_count to 2^32−1 and adding one stall → wraps to 0.
